ir_sweep_gen: RTL and testbench

- Hardware stimulus engine that steps an instruction-register value through a programmable range and compacts the decoder outputs into a signature.
- It is the parametrised, synthesizable successor of the fixed opcode sweep used to exercise APR IR decode.
- Start, end, step, settle time, IR width and decode width are generalised.
- It sits beside the APR decoder.
  - It drives `ir_out` into the decoder.
  - It samples the decoder's flag vector into a MISR so the whole sweep reduces to one comparable word plus a sample count.

---
 rtl/ir_sweep_gen_if.sv | 45 ++++
 rtl/ir_sweep_gen.sv | 132 +++++++++++++
 tb/tb_ir_sweep_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ir_sweep_gen_if.sv
// ir_sweep_gen_if: control/config/result bundle for the IR sweep generator.
//   master : stimulus side (drives start/abort/cfg_*/dec_in, reads results)
//   slave  : ir_sweep_gen (reads controls, drives ir_out/busy/done/aborted/sig/count)
// Optional macro SWEEP_PAUSE_EN adds the 'pause' control signal.
interface ir_sweep_gen_if #(
  parameter int unsigned IR_W  = 18,
  parameter int unsigned DEC_W = 32,
  parameter int unsigned SIG_W = 36,
  parameter int unsigned CNT_W = IR_W + 1
);
  logic             start;
  logic             abort;
  logic [IR_W-1:0]  cfg_start;
  logic [IR_W-1:0]  cfg_end;
  logic [IR_W-1:0]  cfg_step;
  logic [DEC_W-1:0] dec_in;
  logic [IR_W-1:0]  ir_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] count;

`ifdef SWEEP_PAUSE_EN
  logic             pause;

  modport master (
    output start, abort, cfg_start, cfg_end, cfg_step, dec_in, pause,
    input  ir_out, busy, done, aborted, sig, count
  );
  modport slave (
    input  start, abort, cfg_start, cfg_end, cfg_step, dec_in, pause,
    output ir_out, busy, done, aborted, sig, count
  );
`else
  modport master (
    output start, abort, cfg_start, cfg_end, cfg_step, dec_in,
    input  ir_out, busy, done, aborted, sig, count
  );
  modport slave (
    input  start, abort, cfg_start, cfg_end, cfg_step, dec_in,
    output ir_out, busy, done, aborted, sig, count
  );
`endif
endinterface

// File: rtl/ir_sweep_gen.sv
// ir_sweep_gen: steps an IR value from cfg_start to cfg_end (inclusive) by
// cfg_step (0 treated as 1), holding each value SETTLE cycles before
// compacting the decoder flags into a MISR signature and counting samples.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ir_sweep_gen_if.slave
//                in : start, abort, cfg_start, cfg_end, cfg_step, dec_in
//                out: ir_out, busy, done, aborted, sig, count
// Optional macro SWEEP_PAUSE_EN: adds bus.pause, freezing HOLD/SAMPLE progress.
module ir_sweep_gen #(
  parameter int unsigned       IR_W   = 18,
  parameter int unsigned       DEC_W  = 32,
  parameter int unsigned       SIG_W  = 36,
  parameter logic [SIG_W-1:0]  POLY   = 36'o000000000243,
  parameter int unsigned       SETTLE = 1,
  parameter int unsigned       CNT_W  = IR_W + 1
) (
  input  logic            clk,
  input  logic            reset,
  ir_sweep_gen_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam int unsigned    HW       = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [HW-1:0]  SETTLE_L = HW'(SETTLE);
  // With no settle time a point goes straight to its sample cycle.
  localparam logic [1:0]     PT_ENTRY = (SETTLE == 0) ? SAMPLE : HOLD;

  logic [1:0]       state;
  logic [IR_W-1:0]  ir_q;
  logic [IR_W-1:0]  end_q;
  logic [IR_W-1:0]  step_q;
  logic [HW-1:0]    hold_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic [SIG_W-1:0] sig_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IR_W:0]    nxt;
  logic             last_pt;
  logic [SIG_W-1:0] misr_nxt;
  logic             run_en;

`ifdef SWEEP_PAUSE_EN
  assign run_en = ~bus.pause;
`else
  assign run_en = 1'b1;
`endif

  always_comb begin
    // Extra carry bit catches wrap past the top of the IR range.
    nxt      = {1'b0, ir_q} + {1'b0, step_q};
    last_pt  = nxt[IR_W] || (nxt[IR_W-1:0] > end_q);
    misr_nxt = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(bus.dec_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ir_q      <= '0;
      end_q     <= '0;
      step_q    <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      sig_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      // busy is high only in HOLD/SAMPLE; abort there pre-empts any sample.
      if (busy_q && bus.abort) begin
        state     <= IDLE;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              ir_q   <= bus.cfg_start;
              end_q  <= bus.cfg_end;
              step_q <= (bus.cfg_step == '0) ? IR_W'(1) : bus.cfg_step;
              busy_q <= 1'b1;
              sig_q  <= '0;
              cnt_q  <= '0;
              hold_q <= SETTLE_L;
              state  <= PT_ENTRY;
            end
          end
          HOLD: begin
            if (run_en) begin
              hold_q <= hold_q - 1'b1;
              if (hold_q <= HW'(1)) state <= SAMPLE;
            end
          end
          SAMPLE: begin
            if (run_en) begin
              sig_q <= misr_nxt;
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
              if (last_pt) begin
                state  <= FINISH;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                ir_q   <= nxt[IR_W-1:0];
                hold_q <= SETTLE_L;
                state  <= PT_ENTRY;
              end
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ir_out  = ir_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.sig     = sig_q;
  assign bus.count   = cnt_q;

endmodule

// File: tb/tb_ir_sweep_gen.sv
// tb_ir_sweep_gen: directed, table-driven check of ir_sweep_gen (SETTLE=1)
// plus hand-written abort/reset/start-collision sequences.
module tb_ir_sweep_gen;
  localparam int unsigned IR_W  = 18;
  localparam int unsigned DEC_W = 32;
  localparam int unsigned SIG_W = 36;
  localparam int unsigned CNT_W = 19;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ir_sweep_gen_if #(.IR_W(IR_W), .DEC_W(DEC_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

  ir_sweep_gen #(
    .IR_W(IR_W), .DEC_W(DEC_W), .SIG_W(SIG_W),
    .POLY(36'o000000000243), .SETTLE(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Fake decoder: 0 = all-zero flags, 1 = flags mirror ir_out, 2 = only bit 31.
  logic [1:0] dec_mode;
  assign bus.dec_in = (dec_mode == 2'd1) ? DEC_W'(bus.ir_out) :
                      (dec_mode == 2'd2) ? 32'h8000_0000 : '0;

  typedef struct {
    logic [17:0] cs;
    logic [17:0] ce;
    logic [17:0] st;
    logic [1:0]  mode;
    int unsigned n;
    logic [35:0] sig;
    logic [17:0] last;
  } vec_t;

  vec_t vt [6];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ir"},      64'(bus.ir_out),  64'd0);
    chk({tag, "_busy"},    64'(bus.busy),    64'd0);
    chk({tag, "_done"},    64'(bus.done),    64'd0);
    chk({tag, "_aborted"}, 64'(bus.aborted), 64'd0);
    chk({tag, "_sig"},     64'(bus.sig),     64'd0);
    chk({tag, "_count"},   64'(bus.count),   64'd0);
  endtask

  // Wait (bounded) for done; returns negedges elapsed.
  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int unsigned cyc;
    logic [17:0] stp, exp_ir, prev;
    logic        seq_ok;
    int unsigned done_seen;

    // cs, ce, step, mode, points, signature, final ir_out
    vt[0] = '{18'o0,      18'o677,    18'o1,  2'd0, 448, 36'h0,         18'o677};
    vt[1] = '{18'o700000, 18'o700340, 18'o40, 2'd0, 8,   36'h0,         18'o700340};
    vt[2] = '{18'o5,      18'o7,      18'o0,  2'd1, 3,   36'h1F,        18'o7};
    vt[3] = '{18'o20,     18'o10,     18'o1,  2'd1, 1,   36'h10,        18'o20};
    vt[4] = '{18'o777770, 18'o777777, 18'o5,  2'd1, 2,   36'h4000D,     18'o777775};
    vt[5] = '{18'o0,      18'o5,      18'o1,  2'd2, 6,   36'hF800000A3, 18'o5};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_start = '0;
    bus.cfg_end   = '0;
    bus.cfg_step  = '0;
    dec_mode      = 2'd0;
`ifdef SWEEP_PAUSE_EN
    bus.pause     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cfg_start = vt[i].cs;
      bus.cfg_end   = vt[i].ce;
      bus.cfg_step  = vt[i].st;
      dec_mode      = vt[i].mode;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      stp    = (vt[i].st == '0) ? 18'd1 : vt[i].st;
      exp_ir = vt[i].cs;
      prev   = bus.ir_out;
      seq_ok = (bus.ir_out === exp_ir) && (bus.busy === 1'b1);
      cyc    = 0;
      while (bus.done !== 1'b1 && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        if (bus.busy === 1'b1 && bus.ir_out !== prev) begin
          exp_ir = exp_ir + stp;
          if (bus.ir_out !== exp_ir) seq_ok = 1'b0;
          prev = bus.ir_out;
        end
      end
      chk($sformatf("v%0d_cycles", i), 64'(cyc),         64'(2 * vt[i].n));
      chk($sformatf("v%0d_count", i),  64'(bus.count),   64'(vt[i].n));
      chk($sformatf("v%0d_sig", i),    64'(bus.sig),     64'(vt[i].sig));
      chk($sformatf("v%0d_last", i),   64'(bus.ir_out),  64'(vt[i].last));
      chk($sformatf("v%0d_seq", i),    64'(seq_ok),      64'd1);
      chk($sformatf("v%0d_busy", i),   64'(bus.busy),    64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done1", i),  64'(bus.done),    64'd0);
      chk($sformatf("v%0d_hold", i),   64'(bus.count),   64'(vt[i].n));
    end

    // Abort in the sample cycle of the 4th point: partial results kept.
    @(negedge clk);
    bus.cfg_start = 18'o1;
    bus.cfg_end   = 18'o677;
    bus.cfg_step  = 18'o1;
    dec_mode      = 2'd1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.count !== 19'd3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach3", 64'(cyc < 100), 64'd1);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy",    64'(bus.busy),    64'd0);
    chk("abort_pulse",   64'(bus.aborted), 64'd1);
    chk("abort_done",    64'(bus.done),    64'd0);
    chk("abort_count",   64'(bus.count),   64'd3);
    chk("abort_sig",     64'(bus.sig),     64'd3);
    done_seen = 0;
    @(negedge clk);
    chk("abort_pulse1",  64'(bus.aborted), 64'd0);
    repeat (6) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      @(negedge clk);
    end
    chk("abort_nodone",  64'(done_seen),   64'd0);

    // start while busy is ignored.
    bus.cfg_start = 18'o5;
    bus.cfg_end   = 18'o7;
    bus.cfg_step  = 18'o0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.cfg_start = 18'o100;
    bus.cfg_end   = 18'o200;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("rebusy_timeout", 64'(cyc < 4000), 64'd1);
    chk("rebusy_count",   64'(bus.count),  64'd3);
    chk("rebusy_sig",     64'(bus.sig),    64'h1F);
    chk("rebusy_ir",      64'(bus.ir_out), 64'o7);
    @(negedge clk);

    // start and abort together in IDLE: nothing starts.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("collide_busy",  64'(bus.busy),    64'd0);
    chk("collide_abt",   64'(bus.aborted), 64'd0);
    @(negedge clk);
    chk("collide_busy2", 64'(bus.busy),    64'd0);
    chk("collide_count", 64'(bus.count),   64'd3);

    // abort alone in IDLE: no effect.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idleabt_pulse", 64'(bus.aborted), 64'd0);
    chk("idleabt_sig",   64'(bus.sig),     64'h1F);

    // reset mid-sweep clears everything on the next edge.
    bus.cfg_start = 18'o0;
    bus.cfg_end   = 18'o677;
    bus.cfg_step  = 18'o1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midrst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle", 64'(bus.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
